// File: rtl/load_hazard_scoreboard.sv
// Decode-stage load/use hazard scoreboard: per-register countdown of cycles until a
// result is obtainable, producing decode stalls, bubble injection and a stall counter.
module load_hazard_scoreboard #(
  parameter int unsigned NREG         = 16,
  parameter int unsigned NSRC         = 3,
  parameter int unsigned LOAD_LATENCY = 2,
  parameter int unsigned ALU_LATENCY  = 0,
  parameter int unsigned FWD_EN       = 1,
  parameter int unsigned PIPE_DEPTH   = 3,
  localparam int unsigned RW          = $clog2(NREG),
  localparam int unsigned CW          = $clog2(PIPE_DEPTH + LOAD_LATENCY + ALU_LATENCY + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     dec_valid,
  input  logic [NSRC-1:0]          dec_src_valid,
  input  logic [NSRC-1:0][RW-1:0]  dec_src,
  input  logic                     dec_dst_valid,
  input  logic [RW-1:0]            dec_dst,
  input  logic                     dec_is_load,
  input  logic                     flush,
  output logic                     stall_pc,
  output logic [NSRC-1:0]          stall_src_mask,
  output logic                     stall_phase,
  output logic [NREG-1:0]          busy_mask,
  output logic [31:0]              stall_cycles
);

  // Without forwarding, consumers wait for register-file writeback.
  localparam int unsigned LAT_LOAD = (FWD_EN != 0) ? LOAD_LATENCY : PIPE_DEPTH + LOAD_LATENCY;
  localparam int unsigned LAT_ALU  = (FWD_EN != 0) ? ALU_LATENCY  : PIPE_DEPTH;

  logic [NREG-1:0][CW-1:0] cnt_q, cnt_d;
  logic [NREG-1:0]         busy_q, busy_d;
  logic                    stall_phase_q, stall_phase_d;
  logic [31:0]             stall_cycles_q, stall_cycles_d;
  logic                    issue;
  logic [CW-1:0]           lat;

  // Hazard detection against pre-update counters.
  always_comb begin
    stall_src_mask = '0;
    for (int i = 0; i < int'(NSRC); i++) begin
      stall_src_mask[i] = dec_valid & dec_src_valid[i] & ~flush & (cnt_q[dec_src[i]] != '0);
    end
    stall_pc = |stall_src_mask;
    issue    = dec_valid & ~stall_pc & ~flush;
    lat      = dec_is_load ? CW'(LAT_LOAD) : CW'(LAT_ALU);
  end

  // Counter update: flush clears, else count down, then a newer issue overrides its destination.
  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else begin
      for (int r = 0; r < int'(NREG); r++) begin
        if (cnt_q[r] != '0) cnt_d[r] = cnt_q[r] - CW'(1);
      end
      if (issue && dec_dst_valid) cnt_d[dec_dst] = lat;
    end
    busy_d = '0;
    for (int r = 0; r < int'(NREG); r++) begin
      busy_d[r] = (cnt_d[r] != '0);
    end
    stall_phase_d  = stall_pc;
    stall_cycles_d = stall_cycles_q;
    if (stall_pc && (stall_cycles_q != 32'hFFFF_FFFF)) stall_cycles_d = stall_cycles_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q          <= '0;
      busy_q         <= '0;
      stall_phase_q  <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      cnt_q          <= cnt_d;
      busy_q         <= busy_d;
      stall_phase_q  <= stall_phase_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign busy_mask    = busy_q;
  assign stall_phase  = stall_phase_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_load_hazard_scoreboard.sv
// Directed bench for load_hazard_scoreboard: a forwarding instance and a writeback-only
// instance share stimulus; each scenario task checks its own expected values.
module tb_load_hazard_scoreboard;

  logic            clk;
  logic            rst;
  logic            dec_valid;
  logic [2:0]      dec_src_valid;
  logic [2:0][3:0] dec_src;
  logic            dec_dst_valid;
  logic [3:0]      dec_dst;
  logic            dec_is_load;
  logic            flush;

  logic            stall_pc_f, stall_phase_f, stall_pc_n, stall_phase_n;
  logic [2:0]      mask_f, mask_n;
  logic [15:0]     busy_f, busy_n;
  logic [31:0]     cycles_f, cycles_n;

  int checks = 0;
  int errors = 0;

  load_hazard_scoreboard #(.FWD_EN(1)) dut_f (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_src_valid(dec_src_valid),
    .dec_src(dec_src), .dec_dst_valid(dec_dst_valid), .dec_dst(dec_dst),
    .dec_is_load(dec_is_load), .flush(flush), .stall_pc(stall_pc_f),
    .stall_src_mask(mask_f), .stall_phase(stall_phase_f), .busy_mask(busy_f),
    .stall_cycles(cycles_f)
  );

  load_hazard_scoreboard #(.FWD_EN(0), .PIPE_DEPTH(3)) dut_n (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_src_valid(dec_src_valid),
    .dec_src(dec_src), .dec_dst_valid(dec_dst_valid), .dec_dst(dec_dst),
    .dec_is_load(dec_is_load), .flush(flush), .stall_pc(stall_pc_n),
    .stall_src_mask(mask_n), .stall_phase(stall_phase_n), .busy_mask(busy_n),
    .stall_cycles(cycles_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] sv, input logic [3:0] s0,
                       input logic [3:0] s1, input logic [3:0] s2, input logic dv,
                       input logic [3:0] d, input logic ld);
    dec_valid     = v;
    dec_src_valid = sv;
    dec_src[0]    = s0;
    dec_src[1]    = s1;
    dec_src[2]    = s2;
    dec_dst_valid = dv;
    dec_dst       = d;
    dec_is_load   = ld;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic do_reset();
    flush = 1'b0;
    rst   = 1'b1;
    idle();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    flush = 1'b0;
    rst   = 1'b1;
    idle();
    step();
    step();
    checks++; if (busy_f !== 16'h0000) begin errors++; $display("FAIL reset_busy got %h exp 0000", busy_f); end
    checks++; if (stall_phase_f !== 1'b0) begin errors++; $display("FAIL reset_phase got %b exp 0", stall_phase_f); end
    checks++; if (cycles_f !== 32'd0) begin errors++; $display("FAIL reset_cycles got %h exp 0", cycles_f); end
    checks++; if (stall_pc_f !== 1'b0 || mask_f !== 3'b000) begin errors++; $display("FAIL reset_stall got %b/%b exp 0/000", stall_pc_f, mask_f); end
    rst = 1'b0;
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1'b1, 3'b000, 4'd0, 4'd0, 4'd0, 1'b1, 4'd3, 1'b1);
    checks++; if (stall_pc_f !== 1'b0) begin errors++; $display("FAIL lu_T_stall got %b exp 0", stall_pc_f); end
    step();
    drive(1'b1, 3'b010, 4'd0, 4'd3, 4'd0, 1'b1, 4'd5, 1'b0);
    checks++; if (stall_pc_f !== 1'b1 || mask_f !== 3'b010) begin errors++; $display("FAIL lu_T1_stall got %b/%b exp 1/010", stall_pc_f, mask_f); end
    checks++; if (stall_phase_f !== 1'b0) begin errors++; $display("FAIL lu_T1_phase got %b exp 0", stall_phase_f); end
    checks++; if (busy_f !== 16'h0008) begin errors++; $display("FAIL lu_T1_busy got %h exp 0008", busy_f); end
    step();
    checks++; if (stall_pc_f !== 1'b1 || stall_phase_f !== 1'b1) begin errors++; $display("FAIL lu_T2 got pc=%b ph=%b exp 1/1", stall_pc_f, stall_phase_f); end
    checks++; if (busy_f !== 16'h0008) begin errors++; $display("FAIL lu_T2_busy got %h exp 0008", busy_f); end
    step();
    checks++; if (stall_pc_f !== 1'b0 || stall_phase_f !== 1'b1) begin errors++; $display("FAIL lu_T3 got pc=%b ph=%b exp 0/1", stall_pc_f, stall_phase_f); end
    checks++; if (busy_f !== 16'h0000) begin errors++; $display("FAIL lu_T3_busy got %h exp 0000", busy_f); end
    step();
    idle();
    checks++; if (stall_phase_f !== 1'b0) begin errors++; $display("FAIL lu_T4_phase got %b exp 0", stall_phase_f); end
    checks++; if (cycles_f !== 32'd2) begin errors++; $display("FAIL lu_cycles got %0d exp 2", cycles_f); end
  endtask

  task automatic test_alu_back_to_back();
    do_reset();
    drive(1'b1, 3'b000, 4'd0, 4'd0, 4'd0, 1'b1, 4'd1, 1'b0);
    checks++; if (stall_pc_f !== 1'b0 || busy_f !== 16'h0000) begin errors++; $display("FAIL alu0 got pc=%b busy=%h exp 0/0000", stall_pc_f, busy_f); end
    step();
    drive(1'b1, 3'b001, 4'd1, 4'd0, 4'd0, 1'b1, 4'd1, 1'b0);
    checks++; if (stall_pc_f !== 1'b0 || busy_f !== 16'h0000) begin errors++; $display("FAIL alu1 got pc=%b busy=%h exp 0/0000", stall_pc_f, busy_f); end
    step();
    drive(1'b1, 3'b011, 4'd1, 4'd1, 4'd0, 1'b1, 4'd1, 1'b0);
    checks++; if (stall_pc_f !== 1'b0 || busy_f !== 16'h0000) begin errors++; $display("FAIL alu2 got pc=%b busy=%h exp 0/0000", stall_pc_f, busy_f); end
    step();
    idle();
    checks++; if (cycles_f !== 32'd0 || busy_f !== 16'h0000) begin errors++; $display("FAIL alu_end got cyc=%0d busy=%h exp 0/0000", cycles_f, busy_f); end
  endtask

  task automatic test_no_forwarding();
    do_reset();
    drive(1'b1, 3'b000, 4'd0, 4'd0, 4'd0, 1'b1, 4'd7, 1'b1);
    step();
    drive(1'b1, 3'b101, 4'd2, 4'd7, 4'd7, 1'b0, 4'd0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      checks++; if (stall_pc_n !== 1'b1 || mask_n !== 3'b100) begin errors++; $display("FAIL nf_stall%0d got %b/%b exp 1/100", k, stall_pc_n, mask_n); end
      checks++; if (busy_n !== 16'h0080) begin errors++; $display("FAIL nf_busy%0d got %h exp 0080", k, busy_n); end
      step();
    end
    checks++; if (stall_pc_n !== 1'b0 || stall_phase_n !== 1'b1) begin errors++; $display("FAIL nf_release got pc=%b ph=%b exp 0/1", stall_pc_n, stall_phase_n); end
    step();
    idle();
    checks++; if (cycles_n !== 32'd5) begin errors++; $display("FAIL nf_cycles got %0d exp 5", cycles_n); end
  endtask

  task automatic test_waw();
    do_reset();
    drive(1'b1, 3'b000, 4'd0, 4'd0, 4'd0, 1'b1, 4'd2, 1'b1);
    step();
    drive(1'b1, 3'b000, 4'd0, 4'd0, 4'd0, 1'b1, 4'd2, 1'b0);
    checks++; if (stall_pc_f !== 1'b0 || busy_f !== 16'h0004) begin errors++; $display("FAIL waw_T1 got pc=%b busy=%h exp 0/0004", stall_pc_f, busy_f); end
    step();
    drive(1'b1, 3'b001, 4'd2, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
    checks++; if (stall_pc_f !== 1'b0 || busy_f !== 16'h0000) begin errors++; $display("FAIL waw_T2 got pc=%b busy=%h exp 0/0000", stall_pc_f, busy_f); end
    step();
    idle();
  endtask

  task automatic test_flush();
    do_reset();
    drive(1'b1, 3'b000, 4'd0, 4'd0, 4'd0, 1'b1, 4'd4, 1'b1);
    step();
    flush = 1'b1;
    drive(1'b1, 3'b001, 4'd4, 4'd0, 4'd0, 1'b1, 4'd9, 1'b1);
    checks++; if (stall_pc_f !== 1'b0 || mask_f !== 3'b000) begin errors++; $display("FAIL fl_T1 got %b/%b exp 0/000", stall_pc_f, mask_f); end
    checks++; if (busy_f !== 16'h0010) begin errors++; $display("FAIL fl_T1_busy got %h exp 0010", busy_f); end
    step();
    flush = 1'b0;
    #1;
    checks++; if (busy_f !== 16'h0000) begin errors++; $display("FAIL fl_T2_busy got %h exp 0000", busy_f); end
    checks++; if (stall_pc_f !== 1'b0 || stall_phase_f !== 1'b0) begin errors++; $display("FAIL fl_T2 got pc=%b ph=%b exp 0/0", stall_pc_f, stall_phase_f); end
    step();
    idle();
    checks++; if (busy_f !== 16'h0200) begin errors++; $display("FAIL fl_reissue_busy got %h exp 0200", busy_f); end
    checks++; if (cycles_f !== 32'd0) begin errors++; $display("FAIL fl_cycles got %0d exp 0", cycles_f); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    drive(1'b1, 3'b000, 4'd0, 4'd0, 4'd0, 1'b1, 4'd3, 1'b1);
    step();
    drive(1'b1, 3'b001, 4'd3, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
    checks++; if (stall_pc_f !== 1'b1) begin errors++; $display("FAIL rms_stall got %b exp 1", stall_pc_f); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++; if (stall_pc_f !== 1'b0 || busy_f !== 16'h0000) begin errors++; $display("FAIL rms_after got pc=%b busy=%h exp 0/0000", stall_pc_f, busy_f); end
    checks++; if (stall_phase_f !== 1'b0 || cycles_f !== 32'd0) begin errors++; $display("FAIL rms_regs got ph=%b cyc=%0d exp 0/0", stall_phase_f, cycles_f); end
    step();
    idle();
  endtask

  task automatic test_saturation();
    do_reset();
    drive(1'b1, 3'b000, 4'd0, 4'd0, 4'd0, 1'b1, 4'd3, 1'b1);
    step();
    drive(1'b1, 3'b001, 4'd3, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
    force dut_f.stall_cycles_q = 32'hFFFF_FFFE;
    #1;
    release dut_f.stall_cycles_q;
    #1;
    checks++; if (cycles_f !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sat_preload got %h exp FFFFFFFE", cycles_f); end
    step();
    checks++; if (stall_pc_f !== 1'b1 || cycles_f !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_max got pc=%b cyc=%h exp 1/FFFFFFFF", stall_pc_f, cycles_f); end
    step();
    checks++; if (cycles_f !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_hold got %h exp FFFFFFFF", cycles_f); end
    rst = 1'b1;
    idle();
    step();
    rst = 1'b0;
    #1;
    checks++; if (cycles_f !== 32'd0 || busy_f !== 16'h0000 || stall_phase_f !== 1'b0) begin errors++; $display("FAIL sat_rst got cyc=%h busy=%h ph=%b exp 0/0000/0", cycles_f, busy_f, stall_phase_f); end
    checks++; if (stall_pc_f !== 1'b0 || mask_f !== 3'b000) begin errors++; $display("FAIL sat_rst_stall got %b/%b exp 0/000", stall_pc_f, mask_f); end
  endtask

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    idle();
    test_reset();
    test_load_use();
    test_alu_back_to_back();
    test_no_forwarding();
    test_waw();
    test_flush();
    test_reset_mid_stall();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
